onehot_decoder_seq: RTL and testbench
=====================================

// Module: onehot_decoder_seq
// PURPOSE
//  Parametrised, registered binary-to-one-hot decoder. Generalises the fixed 4-to-16 decoder to AW address bits and NOUT outputs.
//  Two modes: DECODE drives one-hot selects (e.g. register-file write strobes) from a valid/ready address stream.
//  SCAN rotates a single active output on a timed schedule (e.g. display digit multiplexing).
//  Sits between control logic and strobe/enable consumers; all outputs are registered.
// PARAMETERS
//  AW         4   address width
//  NOUT       16  number of outputs; 2 <= NOUT <= 2**AW
//  SCAN_DIV   4   clock cycles per SCAN step; >= 1
//  ACTIVE_LOW 0   1: D is inverted (selected line = 0, others = 1)
// PORTS
//  CLK       in   1     clock, rising edge
//  Reset_n   in   1     asynchronous active-low reset
//  mode      in   1     0 = DECODE, 1 = SCAN; sampled every cycle
//  A         in   AW    address to decode
//  A_valid   in   1     A is valid this cycle
//  A_ready   out  1     block accepts A this cycle
//  D         out  NOUT  one-hot select, polarity per ACTIVE_LOW
//  D_valid   out  1     1-cycle pulse: D updated from an accepted A
//  err       out  1     1-cycle pulse: accepted A >= NOUT
//  scan_idx  out  AW    index currently driven in SCAN mode
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - state=DEC; internal d_reg=0, so D = 0 (ACTIVE_LOW: all ones).
//   - D_valid=0, err=0, scan_idx=0, divider=0.
//  FSM states: DEC, SCAN. Evaluated each clock edge.
//   - DEC -> SCAN when mode=1.
//   - SCAN -> DEC when mode=0.
//  A_ready
//   - Combinational: (state==DEC) && (mode==0).
//   - Accept = A_valid && A_ready.
//  DECODE
//   - Accept with A < NOUT: next cycle d_reg = 1<<A, D_valid=1, err=0.
//   - Accept with A >= NOUT: next cycle d_reg = 0, D_valid=1, err=1.
//   - No accept: d_reg holds its value; D_valid=0, err=0.
//   - Latency is exactly 1 cycle; back-to-back accepts every cycle are supported.
//  Entering SCAN (DEC with mode=1)
//   - Next cycle: d_reg = 1 (output 0), scan_idx=0, divider=0.
//   - Any A_valid in that cycle is ignored; A_ready=0.
//  SCAN
//   - divider counts 0..SCAN_DIV-1.
//   - On divider == SCAN_DIV-1: divider=0, scan_idx = (scan_idx==NOUT-1) ? 0 : scan_idx+1.
//   - d_reg = 1<<new scan_idx, updated on the same edge.
//   - Each output is active for exactly SCAN_DIV cycles.
//   - Wrap goes NOUT-1 -> 0 with no idle gap.
//   - D_valid=0 and err=0 throughout.
//  Leaving SCAN (SCAN with mode=0)
//   - Next cycle: state=DEC, d_reg=0, scan_idx=0, divider=0.
//   - A_ready rises in that next cycle, not in the cycle mode falls.
//  SCAN_DIV=1: output advances every cycle.
//  Output polarity: D = ACTIVE_LOW ? ~d_reg : d_reg. Exactly one or zero bits of d_reg are set at all times.
//  Widths
//   - 1<<A is computed at 2**AW bits and truncated to NOUT.
//   - The range check uses the full AW-bit compare.
//   - divider width is clog2(SCAN_DIV), min 1.
//  Reset mid-SCAN or mid-accept: immediate return to reset values; no pulse survives.
// STRUCTURE
//  Package onehot_decoder_pkg:
//   - MODE_DECODE/MODE_SCAN constants, state encoding ST_DEC/ST_SCAN.
//   - function onehot(idx, n) returning a 2**AW vector.
//  Sub-module scan_stepper: divider + wrapping index counter.
//   - Params: AW, NOUT, SCAN_DIV.
//   - Ports: CLK, Reset_n, clear, en, step, idx.
//  Top: FSM, handshake, d_reg, err/D_valid pulses, polarity.
// TESTING
//  1. Reset, AW=4 NOUT=16: D=16'h0000, A_ready=1, D_valid=0, scan_idx=0.
//  2. A=5 accepted, then A=15 and A=0 on consecutive cycles:
//     D=16'h0020, 16'h8000, 16'h0001 one cycle after each; D_valid high 3 cycles.
//  3. NOUT=10: accept A=12 -> D=0, err=1 and D_valid=1 for one cycle.
//     Then A=9 -> D=10'h200, err=0.
//  4. SCAN, SCAN_DIV=4, NOUT=10: D=1 for 4 cycles, then 2, ..., 10'h200.
//     Then back to 10'h001 with no gap. A_ready=0 throughout.
//  5. mode 1->0 while scan_idx=3: next cycle D=0, A_ready=1.
//     Accept A=2 in that cycle -> D=10'h004 one cycle later.
//  6. ACTIVE_LOW=1: reset D=16'hFFFF; accept A=1 -> D=16'hFFFD.
//     Reset_n pulsed mid-SCAN -> D=16'hFFFF immediately, scan_idx=0.

Source files
------------

// File: rtl/onehot_decoder_pkg.sv
// Shared constants, state encoding and index helpers for the one-hot decoder.
package onehot_decoder_pkg;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest one-hot vector the helpers produce; callers truncate to their NOUT.
    localparam int unsigned MAX_OUT = 256;

    typedef enum logic {
        ST_DEC  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Indices at or above n decode to all zeros.
    function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_OUT-1:0] v;
        v = '0;
        if (idx < n && idx < MAX_OUT) begin
            v[idx[7:0]] = 1'b1;
        end
        return v;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_scan_stepper.sv
// Divider plus wrapping index counter driving the SCAN rotation.
module scan_stepper
    import onehot_decoder_pkg::*;
#(
    parameter int unsigned AW       = 4,
    parameter int unsigned NOUT     = 16,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          clear,
    input  logic          en,
    output logic          step,
    output logic [AW-1:0] idx
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_q;

    // step marks the last cycle of the current index; idx moves on this edge.
    assign step = en && (div_q == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q <= '0;
            idx   <= '0;
        end else if (clear) begin
            div_q <= '0;
            idx   <= '0;
        end else if (en) begin
            if (step) begin
                div_q <= '0;
                idx   <= AW'(wrap_inc(32'(idx), NOUT));
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with a DECODE handshake mode and a timed SCAN rotation mode.
module onehot_decoder_seq
    import onehot_decoder_pkg::*;
#(
    parameter int unsigned AW         = 4,
    parameter int unsigned NOUT       = 16,
    parameter int unsigned SCAN_DIV   = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic            mode,
    input  logic [AW-1:0]   A,
    input  logic            A_valid,
    output logic            A_ready,
    output logic [NOUT-1:0] D,
    output logic            D_valid,
    output logic            err,
    output logic [AW-1:0]   scan_idx,
    output state_t          dbg_state
);

    state_t            state_q, state_d;
    logic [NOUT-1:0]   d_reg, d_next;
    logic              dv_next, err_next;
    logic              accept;
    logic              scan_run;
    logic              step;

    // Handshake: A is taken on a rising edge when A_valid && A_ready; A_ready is
    // combinational and does not depend on A_valid, so a source may hold A_valid high.
    assign A_ready  = (state_q == ST_DEC) && (mode == MODE_DECODE);
    assign accept   = A_valid && A_ready;
    assign scan_run = (state_q == ST_SCAN) && (mode == MODE_SCAN);

    scan_stepper #(
        .AW       (AW),
        .NOUT     (NOUT),
        .SCAN_DIV (SCAN_DIV)
    ) u_stepper (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .clear   (!scan_run),
        .en      (scan_run),
        .step    (step),
        .idx     (scan_idx)
    );

    always_comb begin
        state_d  = state_q;
        d_next   = d_reg;
        dv_next  = 1'b0;
        err_next = 1'b0;
        case (state_q)
            ST_DEC: begin
                if (mode == MODE_SCAN) begin
                    state_d = ST_SCAN;
                    d_next  = NOUT'(onehot(0, NOUT));
                end else if (accept) begin
                    d_next   = NOUT'(onehot(32'(A), NOUT));
                    dv_next  = 1'b1;
                    err_next = (32'(A) >= NOUT);
                end
            end
            ST_SCAN: begin
                if (mode == MODE_SCAN) begin
                    // Follow the stepper so D changes on the same edge as scan_idx.
                    if (step) begin
                        d_next = NOUT'(onehot(wrap_inc(32'(scan_idx), NOUT), NOUT));
                    end
                end else begin
                    state_d = ST_DEC;
                    d_next  = '0;
                end
            end
            default: begin
                state_d = ST_DEC;
                d_next  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_DEC;
            d_reg   <= '0;
            D_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            d_reg   <= d_next;
            D_valid <= dv_next;
            err     <= err_next;
        end
    end

    assign D         = ACTIVE_LOW ? ~d_reg : d_reg;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: three configurations share clock and reset.
module tb_onehot_decoder_seq;
  import onehot_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  // u16: AW=4 NOUT=16 SCAN_DIV=4 active-high
  logic        m16 = 1'b0, av16 = 1'b0, rdy16, dv16, err16;
  logic [3:0]  a16 = '0, idx16;
  logic [15:0] d16;
  state_t      st16;
  // u10: AW=4 NOUT=10 SCAN_DIV=4 active-high
  logic        m10 = 1'b0, av10 = 1'b0, rdy10, dv10, err10;
  logic [3:0]  a10 = '0, idx10;
  logic [9:0]  d10;
  state_t      st10;
  // ul: AW=4 NOUT=16 SCAN_DIV=1 active-low
  logic        ml = 1'b0, avl = 1'b0, rdyl, dvl, errl;
  logic [3:0]  al = '0, idxl;
  logic [15:0] dl;
  state_t      stl;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  onehot_decoder_seq #(.AW(4), .NOUT(16), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u16 (
    .CLK(clk), .Reset_n(rst_n), .mode(m16), .A(a16), .A_valid(av16), .A_ready(rdy16),
    .D(d16), .D_valid(dv16), .err(err16), .scan_idx(idx16), .dbg_state(st16)
  );
  onehot_decoder_seq #(.AW(4), .NOUT(10), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u10 (
    .CLK(clk), .Reset_n(rst_n), .mode(m10), .A(a10), .A_valid(av10), .A_ready(rdy10),
    .D(d10), .D_valid(dv10), .err(err10), .scan_idx(idx10), .dbg_state(st10)
  );
  onehot_decoder_seq #(.AW(4), .NOUT(16), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) ul (
    .CLK(clk), .Reset_n(rst_n), .mode(ml), .A(al), .A_valid(avl), .A_ready(rdyl),
    .D(dl), .D_valid(dvl), .err(errl), .scan_idx(idxl), .dbg_state(stl)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare D against the next queued value on every D_valid pulse
  task automatic sb_sample16();
    if (dv16) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_dvalid", 32'(dv16), 32'h0);
      end else begin
        check_eq("sb_d16", 32'(d16), exp_q.pop_front());
      end
    end
  endtask

  logic [15:0] seq_exp [3] = '{16'h0020, 16'h8000, 16'h0001};
  logic [3:0]  seq_addr [3] = '{4'd5, 4'd15, 4'd0};
  logic [9:0]  scan_exp [10] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
                                 10'h020, 10'h040, 10'h080, 10'h100, 10'h200};
  logic [3:0]  err_addr [3] = '{4'd12, 4'd9, 4'd10};
  logic [9:0]  err_d    [3] = '{10'h000, 10'h200, 10'h000};
  logic        err_e    [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // 1. reset state
    check_eq("rst_d16", 32'(d16), 32'h0000);
    check_eq("rst_ready16", 32'(rdy16), 32'h1);
    check_eq("rst_dvalid16", 32'(dv16), 32'h0);
    check_eq("rst_idx16", 32'(idx16), 32'h0);
    check_eq("rst_dl", 32'(dl), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_d16", 32'(d16), 32'h0000);

    // 2. back-to-back accepts on u16
    for (int i = 0; i < 3; i++) begin
      a16 = seq_addr[i];
      av16 = 1'b1;
      exp_q.push_back(32'(seq_exp[i]));
      tick();
      check_eq("b2b_dvalid", 32'(dv16), 32'h1);
      sb_sample16();
    end
    av16 = 1'b0;
    tick();
    check_eq("b2b_dvalid_drop", 32'(dv16), 32'h0);
    check_eq("b2b_hold_d", 32'(d16), 32'h0001);
    check_eq("sb_drained", 32'(exp_q.size()), 32'h0);

    // 3. out-of-range addresses on u10 (12, then 9, then 10 == NOUT)
    for (int i = 0; i < 3; i++) begin
      a10 = err_addr[i];
      av10 = 1'b1;
      tick();
      check_eq("rng_d10", 32'(d10), 32'(err_d[i]));
      check_eq("rng_err", 32'(err10), 32'(err_e[i]));
      check_eq("rng_dvalid", 32'(dv10), 32'h1);
    end
    av10 = 1'b0;
    tick();
    check_eq("rng_err_pulse", 32'(err10), 32'h0);
    check_eq("rng_dvalid_pulse", 32'(dv10), 32'h0);

    // 4. SCAN on u10; a pending A must be ignored
    m10 = 1'b1;
    a10 = 4'd3;
    av10 = 1'b1;
    #1;
    check_eq("scan_enter_ready", 32'(rdy10), 32'h0);
    tick();
    av10 = 1'b0;
    check_eq("scan_state", 32'(st10), 32'(ST_SCAN));
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        check_eq("scan_d10", 32'(d10), 32'(scan_exp[k]));
        check_eq("scan_ready", 32'(rdy10), 32'h0);
        check_eq("scan_dvalid", 32'(dv10 | err10), 32'h0);
        tick();
      end
    end
    check_eq("scan_wrap_d10", 32'(d10), 32'h001);
    check_eq("scan_wrap_idx", 32'(idx10), 32'h0);

    // 5. leave SCAN while scan_idx == 3
    repeat (12) tick();
    check_eq("leave_idx", 32'(idx10), 32'h3);
    check_eq("leave_d10", 32'(d10), 32'h008);
    m10 = 1'b0;
    #1;
    check_eq("leave_ready_same_cycle", 32'(rdy10), 32'h0);
    tick();
    check_eq("leave_d10_clear", 32'(d10), 32'h000);
    check_eq("leave_ready", 32'(rdy10), 32'h1);
    check_eq("leave_idx_clear", 32'(idx10), 32'h0);
    a10 = 4'd2;
    av10 = 1'b1;
    tick();
    av10 = 1'b0;
    check_eq("leave_accept_d10", 32'(d10), 32'h004);
    check_eq("leave_accept_dvalid", 32'(dv10), 32'h1);

    // 6. active-low instance, SCAN_DIV=1, async reset mid-SCAN
    al = 4'd1;
    avl = 1'b1;
    tick();
    avl = 1'b0;
    check_eq("al_accept_d", 32'(dl), 32'hFFFD);
    check_eq("al_accept_dvalid", 32'(dvl), 32'h1);
    ml = 1'b1;
    tick();
    check_eq("al_scan0", 32'(dl), 32'hFFFE);
    tick();
    check_eq("al_scan1", 32'(dl), 32'hFFFD);
    tick();
    check_eq("al_scan2", 32'(dl), 32'hFFFB);
    check_eq("al_scan2_idx", 32'(idxl), 32'h2);
    repeat (14) tick();
    check_eq("al_wrap", 32'(dl), 32'hFFFE);
    check_eq("al_wrap_idx", 32'(idxl), 32'h0);
    repeat (5) tick();
    check_eq("al_pre_rst_idx", 32'(idxl), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("al_rst_d", 32'(dl), 32'hFFFF);
    check_eq("al_rst_idx", 32'(idxl), 32'h0);
    check_eq("al_rst_state", 32'(stl), 32'(ST_DEC));
    ml = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("al_after_rst_d", 32'(dl), 32'hFFFF);
    check_eq("al_after_rst_ready", 32'(rdyl), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
